// File: rtl/store_buffer_if.sv
// ---------------------------------------------------------------------------
// store_buffer_if
// Bundles the store, load and data-memory signals of the store buffer.
//   Store channel : st_valid, st_ready, st_addr, st_data
//   Load channel  : ld_valid, ld_ready, ld_addr, ld_data
//   Memory port   : dm_mem_write, dm_mem_read, dm_address, dm_write_data,
//                   dm_read_data
// Modports:
//   slave  - the store buffer itself
//   master - its environment (pipeline stage plus data memory)
// ---------------------------------------------------------------------------
interface store_buffer_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          st_valid;
   logic          st_ready;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_data;

   logic          ld_valid;
   logic          ld_ready;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;

   logic          dm_mem_write;
   logic          dm_mem_read;
   logic [AW-1:0] dm_address;
   logic [DW-1:0] dm_write_data;
   logic [DW-1:0] dm_read_data;

   modport slave (
      input  st_valid, st_addr, st_data,
      input  ld_valid, ld_addr,
      input  dm_read_data,
      output st_ready, ld_ready, ld_data,
      output dm_mem_write, dm_mem_read, dm_address, dm_write_data
   );

   modport master (
      output st_valid, st_addr, st_data,
      output ld_valid, ld_addr,
      output dm_read_data,
      input  st_ready, ld_ready, ld_data,
      input  dm_mem_write, dm_mem_read, dm_address, dm_write_data
   );
endinterface

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// Posted-write FIFO between the MEM stage and the data memory. Stores are
// queued and retired in program order, one per cycle, whenever the memory
// port is not claimed by a load. Loads go to memory combinationally; a load
// that matches a buffered store is either forwarded or stalled.
//
// Build option:
//   STORE_FWD_EN  defined   -> a hit returns the youngest matching store's
//                              data and the head keeps draining.
//                 undefined -> a hit stalls the load (ld_ready=0) while the
//                              buffer drains until no matching entry is left.
//
// Ports:
//   clk    - clock, all state changes on posedge
//   reset  - synchronous, active-high; discards buffered stores
//   bus    - store/load/memory signals (store_buffer_if.slave)
//   count  - occupied entries
//   empty  - count == 0 (forced 1 during reset)
//   full   - count == DEPTH
// ---------------------------------------------------------------------------
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   store_buffer_if.slave            bus,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [AW-1:0]    addr_r [DEPTH];
   logic [DW-1:0]    data_r [DEPTH];
   logic [DEPTH-1:0] valid_r;
   logic [PW-1:0]    head_r;
   logic [PW-1:0]    tail_r;
   logic [CW-1:0]    count_r;

   logic             is_empty_s;
   logic             is_full_s;
   logic             hit_s;
   logic             load_mem_s;
   logic             drain_s;
   logic             push_s;
`ifdef STORE_FWD_EN
   logic [DW-1:0]    fwd_data_s;
`endif

   assign is_empty_s = (count_r == {CW{1'b0}});
   assign is_full_s  = (count_r == DEPTH_C);

   // Hit search walks oldest to youngest so the last match is the youngest.
   always_comb begin
      hit_s = 1'b0;
`ifdef STORE_FWD_EN
      fwd_data_s = {DW{1'b0}};
`endif
      for (int k = 0; k < DEPTH; k++) begin
         if (valid_r[head_r + PW'(k)] && (addr_r[head_r + PW'(k)] == bus.ld_addr)) begin
            hit_s = 1'b1;
`ifdef STORE_FWD_EN
            fwd_data_s = data_r[head_r + PW'(k)];
`endif
         end else begin
            hit_s = hit_s;
         end
      end
   end

   // A load that misses owns the port; otherwise the head drains.
   assign load_mem_s = bus.ld_valid && !hit_s;
   assign drain_s    = !reset && !load_mem_s && !is_empty_s;
   assign push_s     = !reset && bus.st_valid && !is_full_s;

   // Memory port and load result arbitration; everything is quiet in reset.
   always_comb begin
      bus.dm_mem_write  = 1'b0;
      bus.dm_mem_read   = 1'b0;
      bus.dm_address    = {AW{1'b0}};
      bus.dm_write_data = {DW{1'b0}};
      bus.ld_ready      = 1'b0;
      bus.ld_data       = {DW{1'b0}};
      if (reset) begin
         bus.ld_ready = 1'b0;
      end else if (load_mem_s) begin
         bus.dm_mem_read = 1'b1;
         bus.dm_address  = bus.ld_addr;
         bus.ld_ready    = 1'b1;
         bus.ld_data     = bus.dm_read_data;
      end else if (drain_s) begin
         bus.dm_mem_write  = 1'b1;
         bus.dm_address    = addr_r[head_r];
         bus.dm_write_data = data_r[head_r];
`ifdef STORE_FWD_EN
         // Here ld_valid implies a hit, so the load is served from the buffer.
         if (bus.ld_valid) begin
            bus.ld_ready = 1'b1;
            bus.ld_data  = fwd_data_s;
         end else begin
            bus.ld_ready = 1'b0;
         end
`endif
      end else begin
         bus.ld_ready = 1'b0;
      end
   end

   // Status outputs, masked while reset is asserted.
   always_comb begin
      if (reset) begin
         bus.st_ready = 1'b0;
         count        = {CW{1'b0}};
         empty        = 1'b1;
         full         = 1'b0;
      end else begin
         bus.st_ready = !is_full_s;
         count        = count_r;
         empty        = is_empty_s;
         full         = is_full_s;
      end
   end

   // Entry payload storage; contents are meaningless until marked valid.
   always_ff @(posedge clk) begin
      if (push_s) begin
         addr_r[tail_r] <= bus.st_addr;
         data_r[tail_r] <= bus.st_data;
      end
   end

   // Pointers, valid bits and occupancy count.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
         valid_r <= {DEPTH{1'b0}};
      end else begin
         if (push_s) begin
            valid_r[tail_r] <= 1'b1;
            tail_r          <= tail_r + 1'b1;
         end
         if (drain_s) begin
            valid_r[head_r] <= 1'b0;
            head_r          <= head_r + 1'b1;
         end
         case ({push_s, drain_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the MEM pipeline stage and the byte-addressable data memory.
- Accepts word stores from the pipeline and retires them to memory in program order, one per cycle, whenever the memory port is not needed by a load.
- Loads go to memory combinationally; a load that hits a buffered store either takes forwarded data or stalls, depending on the build option.

Parameters:
- DEPTH, 4, number of buffered stores (power of 2, >= 2)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  input  1  system clock; all state updates on posedge clk
- reset  input  1  synchronous, active-high reset
- st_valid  input  1  store request
- st_ready  output  1  buffer can accept a store this cycle
- st_addr  input  AW  store address (word-aligned)
- st_data  input  DW  store data
- ld_valid  input  1  load request
- ld_ready  output  1  ld_data valid this cycle; load completes
- ld_addr  input  AW  load address (word-aligned)
- ld_data  output  DW  load result (combinational)
- dm_mem_write  output  1  to data memory mem_write
- dm_mem_read  output  1  to data memory mem_read
- dm_address  output  AW  to data memory address
- dm_write_data  output  DW  to data memory write_data
- dm_read_data  input  DW  from data memory read_data (combinational)
- count  output  $clog2(DEPTH)+1  occupied entries
- empty  output  1  count == 0
- full  output  1  count == DEPTH

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- State: DEPTH entries of {addr, data, valid}, head/tail pointers, count. All update on posedge clk.
- Reset: pointers, count and valid bits go to 0, so buffered stores are discarded. While reset is high, every output is 0 except empty=1.
- Push: st_ready = !full. Data is pushed on st_valid && st_ready at the tail.
  - When full, st_ready=0 even if a drain occurs that cycle.
  - No bypass: a store pushed into an empty buffer drains no earlier than the next cycle.
- Port arbitration each cycle (combinational, in priority order):
  1. Load needing memory: ld_valid, no hit. Set dm_mem_read=1, dm_address=ld_addr, dm_mem_write=0, ld_data=dm_read_data, ld_ready=1. No drain this cycle.
  2. Otherwise, if !empty, drain the head: dm_mem_write=1, dm_address=head addr, dm_write_data=head data. Head pops at posedge (memory writes on the preceding negedge).
  3. Otherwise all dm_* outputs are 0.
- Hit detection: exact AW-bit compare of ld_addr against every valid entry.
  - A store being pushed in the same cycle is not yet visible, so the load sees the pre-store state.
- Simultaneous push and pop: count unchanged and pointers both advance. Pointers wrap modulo DEPTH.
- ld_ready=0 and ld_data=0 whenever ld_valid=0.
- Drain order is strictly FIFO. Consecutive stores to the same address are all written, oldest first.

Optional Feature:
- Macro: STORE_FWD_EN.
- Defined: on a hit, ld_data is the data of the youngest matching entry, ld_ready=1, dm_mem_read=0. The port is free, so the head drains in the same cycle.
- Undefined: on a hit, ld_ready=0 and dm_mem_read=0. The head drains every cycle until no matching entry remains. The load then completes from memory per rule 1.

Test Plan:
- Push stores 0x10=0xAAAA0001, 0x14=0xAAAA0002, 0x18=0xAAAA0003 on consecutive cycles, no loads -> dm_mem_write=1 on 3 consecutive cycles starting 1 cycle after the first push, addresses in order. Memory reads back those values; empty=1 at the end.
- Hold ld_valid with ld_addr=0x100 (mem=0xDEADBEEF) while pushing 5 stores -> no drain, count=4, full=1, st_ready=0 after the 4th push. ld_data=0xDEADBEEF, ld_ready=1 every cycle. Releasing the load drains all 4 in 4 cycles.
- STORE_FWD_EN: buffer 0x20=0x11111111 then 0x20=0x22222222 (drain blocked by a load to 0x100), then load 0x20 -> same cycle ld_ready=1, ld_data=0x22222222, dm_mem_read=0, dm_mem_write=1 to 0x20.
- No STORE_FWD_EN, same setup -> ld_ready=0 for 2 cycles while both entries drain. In the 3rd cycle ld_ready=1 and ld_data=0x22222222 from memory.
- With count=3, assert reset 1 cycle -> next cycle count=0, empty=1, dm_mem_write=0. The 3 target addresses are unchanged in memory.
- At count=2, push and drain in the same cycle -> count stays 2; the tail pointer wraps correctly after DEPTH+1 pushes.
